// File: rtl/game_timer_ctrl.sv
// mm:ss BCD game clock for the end-of-game text ROM.
// Counts in RUN, freezes in HOLD, and saturates at 59:59 instead of wrapping.
module game_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [6:0] minutes_dozens_unity,
  output logic [6:0] seconds_dozens_unity,
  output logic       running,
  output logic       frozen,
  output logic       saturated
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    min_d_q, sec_d_q;
  logic [3:0]    min_u_q, sec_u_q;
  logic [2:0]    min_d_nx, sec_d_nx;
  logic [3:0]    min_u_nx, sec_u_nx;
  logic          at_max;
  logic          sec_tick;

  assign sec_tick = (presc_q == PrescLast);
  assign at_max   = (min_d_q == 3'd5) && (min_u_q == 4'd9) &&
                    (sec_d_q == 3'd5) && (sec_u_q == 4'd9);

  // BCD ripple increment; only applied when not already at 59:59.
  always_comb begin
    min_d_nx = min_d_q;
    min_u_nx = min_u_q;
    sec_d_nx = sec_d_q;
    sec_u_nx = sec_u_q;
    if (sec_u_q != 4'd9) begin
      sec_u_nx = sec_u_q + 4'd1;
    end else begin
      sec_u_nx = 4'd0;
      if (sec_d_q != 3'd5) begin
        sec_d_nx = sec_d_q + 3'd1;
      end else begin
        sec_d_nx = 3'd0;
        if (min_u_q != 4'd9) begin
          min_u_nx = min_u_q + 4'd1;
        end else begin
          min_u_nx = 4'd0;
          min_d_nx = min_d_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      min_d_q   <= '0;
      min_u_q   <= '0;
      sec_d_q   <= '0;
      sec_u_q   <= '0;
      running   <= 1'b0;
      frozen    <= 1'b0;
      saturated <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (start) begin
            state_q   <= StRun;
            presc_q   <= '0;
            min_d_q   <= '0;
            min_u_q   <= '0;
            sec_d_q   <= '0;
            sec_u_q   <= '0;
            running   <= 1'b1;
            frozen    <= 1'b0;
            saturated <= 1'b0;
          end else if (state_q == StIdle) begin
            presc_q <= '0;
          end
        end
        StRun: begin
          if (stop) begin
            // A tick landing on the stop edge is dropped; prescaler is held.
            state_q <= StHold;
            running <= 1'b0;
            frozen  <= 1'b1;
          end else if (sec_tick) begin
            presc_q <= '0;
            if (at_max) begin
              saturated <= 1'b1;
            end else begin
              min_d_q <= min_d_nx;
              min_u_q <= min_u_nx;
              sec_d_q <= sec_d_nx;
              sec_u_q <= sec_u_nx;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end
  end

  assign minutes_dozens_unity = {min_d_q, min_u_q};
  assign seconds_dozens_unity = {sec_d_q, sec_u_q};

endmodule
